// File: rtl/zigbee_pad_arbiter.sv
// rtl/zigbee_pad_arbiter.sv - round-robin owner arbiter for the ZigBee 18-bit output pad bus
//
// Grants the pad bus to one of four requesters per burst (round-robin from the
// requester after the last owner), forwards the owner's accepted words as a
// registered pad word, and inserts GAP idle turnaround cycles between owners.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_i[4]     per-requester bus request (level)
//   valid_i[4]   per-requester word valid
//   last_i[4]    per-requester last word of burst (qualified by valid_i)
//   data_i[4*DW] requester k word at data_i[k*DW +: DW]
//   ready_o[4]   word accepted when valid_i[k] & ready_o[k]
//   grant_o[4]   one-hot current owner, 0 when no owner
//   sel_o[2]     index of current/last owner (pad source select)
//   out_o[DW]    registered pad word
//   out_valid_o  out_o holds a new word this cycle
//   busy_o       arbiter not idle
//
// Optional feature: define ZIGBEE_PAD_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT consecutive stall cycles (owner requesting but not sending).

module zigbee_pad_arbiter #(
  parameter int DW        = 18,
  parameter int MAX_BURST = 16,
  parameter int GAP       = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [3:0]      req_i,
  input  logic [3:0]      valid_i,
  input  logic [3:0]      last_i,
  input  logic [4*DW-1:0] data_i,
  output logic [3:0]      ready_o,
  output logic [3:0]      grant_o,
  output logic [1:0]      sel_o,
  output logic [DW-1:0]   out_o,
  output logic            out_valid_o,
  output logic            busy_o
);

  if (MAX_BURST < 1 || MAX_BURST > 255 || GAP < 0 || GAP > 15 ||
      TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("zigbee_pad_arbiter: parameter out of range");
  end

  localparam logic [7:0] MAX_CNT  = 8'(MAX_BURST);
  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [1:0]      sel_q, sel_d;
  logic [1:0]      last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [3:0]      gap_q, gap_d;
  logic [DW-1:0]   out_q, out_d;
  logic            out_valid_q, out_valid_d;

  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic            win_found;
  logic [DW-1:0]   owner_word;
  logic            beat;
  logic            burst_full;
  logic            stall_hit;
  logic            burst_end;
  logic            gap_done;

  // Round-robin pick: search upward starting one past the last owner, so the
  // previous owner is checked last and cannot win twice while others wait.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_word = data_i[sel_q*DW +: DW];
  assign beat       = (state_q == XFER) && valid_i[sel_q];
  assign burst_full = (cnt_q + 8'd1) == MAX_CNT;
  assign gap_done   = (gap_q == GAP_LAST);

`ifdef ZIGBEE_PAD_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [7:0] stall_q, stall_d;

  // Counts consecutive cycles where the owner still requests but sends nothing.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE) begin
      stall_d = '0;
    end else if (state_q == XFER) begin
      if (beat) begin
        stall_d = '0;
      end else if (req_i[sel_q]) begin
        stall_d = stall_q + 8'd1;
      end
    end
  end

  assign stall_hit = (state_q == XFER) && !beat && req_i[sel_q] &&
                     ((stall_q + 8'd1) == TO_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // The ending beat itself is transferred; a request drop only ends the
  // burst in a cycle where the owner did not deliver a word.
  assign burst_end = (state_q == XFER) &&
                     ((beat && (last_i[sel_q] || burst_full)) ||
                      (!beat && !req_i[sel_q]) ||
                      stall_hit);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|req_i) state_d = XFER;
      XFER: if (burst_end) state_d = (GAP > 0) ? TURN : IDLE;
      TURN: if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    grant_d     = grant_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (beat) begin
          out_d       = owner_word;
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 8'd1;
        end
        if (burst_end) begin
          grant_d = '0;
          last_d  = sel_q;
          gap_d   = '0;
        end
      end
      TURN: begin
        gap_d = gap_q + 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q     <= '0;
      sel_q       <= '0;
      last_q      <= 2'd3;
      cnt_q       <= '0;
      gap_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Outputs
  always_comb begin
    ready_o     = (state_q == XFER) ? grant_q : 4'b0000;
    grant_o     = grant_q;
    sel_o       = sel_q;
    out_o       = out_q;
    out_valid_o = out_valid_q;
    busy_o      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_zigbee_pad_arbiter.sv
// tb/tb_zigbee_pad_arbiter.sv - randomized self-checking bench for zigbee_pad_arbiter
module tb_zigbee_pad_arbiter;

  localparam int DW        = 18;
  localparam int MAX_BURST = 16;
  localparam int GAP       = 1;
  localparam int TIMEOUT   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req, valid, last;
  logic [DW-1:0]   w [4];
  logic [4*DW-1:0] data;
  logic [3:0]      ready_o, grant_o;
  logic [1:0]      sel_o;
  logic [DW-1:0]   out_o;
  logic            out_valid_o, busy_o;

  assign data = {w[3], w[2], w[1], w[0]};

  always #5 clk = ~clk;

  zigbee_pad_arbiter #(
    .DW(DW), .MAX_BURST(MAX_BURST), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .valid_i(valid), .last_i(last),
    .data_i(data), .ready_o(ready_o), .grant_o(grant_o), .sel_o(sel_o),
    .out_o(out_o), .out_valid_o(out_valid_o), .busy_o(busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: who owns the bus, how many words it has sent, and the
  // earliest edge at which a new arbitration may take place.
  int            m_owner;
  int            m_last;
  int            m_sel;
  int            m_words;
  int            m_stall;
  int            m_free_at;
  logic [DW-1:0] m_out;
  bit            m_outv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = 3;
    m_sel     = 0;
    m_words   = 0;
    m_stall   = 0;
    m_free_at = 0;
    m_out     = '0;
    m_outv    = 0;
  endtask

  task automatic model_step();
    bit done;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    m_outv = 0;
    if (m_owner >= 0) begin
      done = 0;
      if (valid[m_owner]) begin
        m_out  = w[m_owner];
        m_outv = 1;
        m_words++;
        m_stall = 0;
        done = last[m_owner] || (m_words == MAX_BURST);
      end else if (!req[m_owner]) begin
        done = 1;
      end else begin
        m_stall++;
`ifdef ZIGBEE_PAD_ARB_TIMEOUT_EN
        if (m_stall == TIMEOUT) done = 1;
`endif
      end
      if (done) begin
        m_last    = m_owner;
        m_owner   = -1;
        m_free_at = cyc + 1 + GAP;
      end
    end else if (cyc >= m_free_at && req != 4'b0000) begin
      for (int i = 1; i <= 4; i++) begin
        if (m_owner < 0 && req[(m_last + i) % 4]) m_owner = (m_last + i) % 4;
      end
      m_sel   = m_owner;
      m_words = 0;
      m_stall = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] g;
    bit         b;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    b = (m_owner >= 0) || (cyc < m_free_at - 1);
    check_eq("grant", 32'(grant_o), 32'(g));
    check_eq("ready", 32'(ready_o), 32'(g));
    check_eq("sel", 32'(sel_o), 32'(m_sel));
    check_eq("out_valid", 32'(out_valid_o), 32'(m_outv));
    check_eq("out", 32'(out_o), 32'(m_out));
    check_eq("busy", 32'(busy_o), 32'(b));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    req = 4'b0000; valid = 4'b0000; last = 4'b0000;
    for (int k = 0; k < 4; k++) w[k] = '0;
  endtask

  initial begin
    int len;
    logic [3:0] mask;
    int vprob, lprob;

    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Single burst from requester 0: three words, last on the third
    req = 4'b0001;
    step();
    valid = 4'b0001; w[0] = 18'h000A1; step();
    w[0] = 18'h000A2; step();
    w[0] = 18'h000A3; last = 4'b0001; step();
    idle_inputs();
    repeat (4) step();

    // All requesters, last on every second word
    req = 4'b1111; valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      for (int k = 0; k < 4; k++) w[k] = 18'(k * 256 + c);
      last = (c % 2 == 1) ? 4'b1111 : 4'b0000;
      step();
    end
    idle_inputs();
    repeat (4) step();

    // Requester 2 streams past MAX_BURST with others pending afterwards
    req = 4'b0100; valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      w[2] = 18'(16'h2000 + c);
      if (c == 3) req = 4'b0111;
      step();
    end
    idle_inputs();
    repeat (4) step();

    // Owner drops request with no valid word; then long stall
    req = 4'b0010; step(); step();
    valid = 4'b0010; w[1] = 18'h11111; step();
    valid = 4'b0000; req = 4'b0000; step(); step();
    req = 4'b0010;
    repeat (50) step();
    idle_inputs();
    repeat (4) step();

    // Reset during word 5 of a burst, then normal grant
    req = 4'b0100; valid = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      w[2] = 18'(18'h30000 + c);
      if (c == 5) rst = 1'b1;
      step();
    end
    rst = 1'b0;
    idle_inputs();
    req = 4'b0100; step(); step();
    valid = 4'b0100; last = 4'b0100; w[2] = 18'h0BEEF; step();
    idle_inputs();
    repeat (3) step();

    // Randomized phases
    for (int p = 0; p < 60; p++) begin
      len   = $urandom_range(10, 60);
      mask  = 4'($urandom);
      vprob = $urandom_range(0, 4);
      lprob = $urandom_range(0, 3);
      for (int c = 0; c < len; c++) begin
        req = mask;
        if ($urandom_range(0, 19) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
        for (int k = 0; k < 4; k++) begin
          valid[k] = ($urandom_range(0, 3) < vprob);
          last[k]  = ($urandom_range(0, 15) < lprob);
          w[k]     = 18'($urandom);
        end
        rst = ($urandom_range(0, 399) == 0);
        step();
      end
    end
    rst = 1'b0;
    idle_inputs();
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
